// File: rtl/spi_shift.sv
// spi_shift: SPI master shift engine paced by the spi_div half-cycle strobe
module spi_shift #(
  parameter int DW     = 8,
  parameter int CS_DLY = 1
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          hlf_cyc,
  input  logic          cpha,
  input  logic          lsb_first,
  input  logic          hold_cs,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          clk_run,
  output logic          clk_tog,
  output logic          spi_cs_n,
  output logic          spi_mosi,
  input  logic          spi_miso,
  output logic          busy
);
  localparam int EW = $clog2(2 * DW);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t        state, state_d;
  logic [3:0]    cnt;
  logic [EW-1:0] ec;
  logic [DW-1:0] sh, rsh, src, nxt, rx_nxt;
  logic          cpha_q, lsb_q, hold_q;
  logic          idle, stb, accept, cnt_done, last_edge, done, ord, ph, cur, entering, present, sample;
  assign idle      = state == IDLE;
  assign stb       = hlf_cyc & ~idle;
  assign accept    = tx_valid & idle;
  assign cnt_done  = stb & (state == SETUP | state == HOLD) & (cnt == 4'(CS_DLY - 1));
  assign last_edge = ec == EW'(2 * DW - 1);
  assign done      = stb & (state == SHIFT) & last_edge;
  // In IDLE the word being accepted is still on the inputs, so bit selection reads them directly.
  assign src       = idle ? tx_data : sh;
  assign ord       = idle ? lsb_first : lsb_q;
  assign ph        = idle ? cpha : cpha_q;
  assign cur       = ord ? src[0] : src[DW-1];
  assign nxt       = ord ? src >> 1 : src << 1;
  assign entering  = (state_d == SHIFT) & (state != SHIFT);
  assign present   = (entering & ~ph) | (stb & (state == SHIFT) & (cpha_q ? ~ec[0] : (ec[0] & ~last_edge)));
  assign sample    = stb & (state == SHIFT) & (cpha_q ? ec[0] : ~ec[0]);
  assign rx_nxt    = lsb_q ? {spi_miso, rsh[DW-1:1]} : {rsh[DW-2:0], spi_miso};
  // State register.
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // Next state and state-decoded outputs; held CS skips SETUP.
  always_comb begin
    state_d  = state;
    tx_ready = idle;
    busy     = ~idle;
    clk_run  = ~idle;
    clk_tog  = state == SHIFT;
    if (accept) state_d = spi_cs_n ? SETUP : SHIFT;
    if (cnt_done) state_d = (state == SETUP) ? SHIFT : IDLE;
    if (done) state_d = hold_q ? IDLE : HOLD;
  end
  // Datapath: CS, strobe counters, shift registers and receive handshake.
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      cnt      <= '0;
      ec       <= '0;
      sh       <= '0;
      rsh      <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      cpha_q   <= accept ? cpha : cpha_q;
      lsb_q    <= accept ? lsb_first : lsb_q;
      hold_q   <= accept ? hold_cs : hold_q;
      spi_cs_n <= accept ? 1'b0 : (cnt_done & state == HOLD) ? 1'b1 : spi_cs_n;
      cnt      <= (state_d != state) ? '0 : cnt + 4'(stb);
      ec       <= (state != SHIFT) ? '0 : stb ? (last_edge ? '0 : ec + 1'b1) : ec;
      sh       <= present ? nxt : accept ? tx_data : sh;
      spi_mosi <= present ? cur : spi_mosi;
      rsh      <= sample ? rx_nxt : rsh;
      rx_data  <= done ? (sample ? rx_nxt : rsh) : rx_data;
      rx_valid <= done;
    end
endmodule

// File: tb/tb_spi_shift.sv
// tb_spi_shift: randomized scoreboard bench with a protocol-level SPI slave model
module tb_spi_shift;
  localparam int DW = 8;
  localparam int CS_DLY = 3;
  logic clk_in = 1'b0, rst_n, hlf_cyc = 1'b0, cpha, lsb_first, hold_cs, tx_valid, spi_miso;
  logic [DW-1:0] tx_data, rx_data;
  logic tx_ready, rx_valid, clk_run, clk_tog, spi_cs_n, spi_mosi, busy;
  spi_shift #(.DW(DW), .CS_DLY(CS_DLY)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .hlf_cyc(hlf_cyc), .cpha(cpha), .lsb_first(lsb_first),
    .hold_cs(hold_cs), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .clk_run(clk_run), .clk_tog(clk_tog),
    .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy)
  );
  always #5 clk_in = ~clk_in;
  int total = 0, passed = 0, extra = 0;
  int unsigned dens = 100;
  logic [DW-1:0] exp_rx[$], exp_mo[$], got_mo[$];
  logic [DW-1:0] nx_s, sw, mw;
  logic nx_ph, nx_lf, nx_hc;
  bit act = 0, held = 0, ph, lf, hc;
  int e, pre, post, exp_pre;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
  endtask
  function automatic logic bitk(input logic [DW-1:0] w, input int k, input logic l);
    return l ? w[k] : w[DW-1-k];
  endfunction
  // Half-cycle strobe source with adjustable density.
  always @(posedge clk_in) begin
    #1;
    hlf_cyc = ($urandom_range(1, 100) <= dens);
  end
  // SPI slave: counts CS setup/hold strobes and SCK edges, captures MOSI, drives MISO.
  always @(negedge clk_in) if (rst_n) begin
    if (act && e == 2 * DW && (hc ? !busy : spi_cs_n)) begin
      if (!hc) chk("hold_strobes", post, CS_DLY);
      act = 0;
      held = hc;
    end
    if (tx_valid && tx_ready) begin
      if (held) chk("cs_held_low", {31'd0, spi_cs_n}, 0);
      exp_pre = held ? 0 : CS_DLY;
      held = 0;
      act = 1; ph = nx_ph; lf = nx_lf; hc = nx_hc; sw = nx_s;
      e = 0; pre = 0; post = 0; mw = '0;
      if (!ph) spi_miso = bitk(sw, 0, lf);
    end else if (hlf_cyc && busy) begin
      if (!clk_tog) begin
        if (act && e == 0) pre++;
        else if (act) post++;
      end else if (!act || e >= 2 * DW) extra++;
      else begin
        if (e == 0) chk("setup_strobes", pre, exp_pre);
        if ((e % 2 == 1) == ph) mw[lf ? e / 2 : DW - 1 - e / 2] = spi_mosi;
        else if (ph) spi_miso = bitk(sw, e / 2, lf);
        else if (e != 2 * DW - 1) spi_miso = bitk(sw, (e + 1) / 2, lf);
        e++;
        if (e == 2 * DW) got_mo.push_back(mw);
      end
    end
  end
  // Monitor: every rx_valid pulse consumes one expected word.
  always @(negedge clk_in) if (rst_n && rx_valid) begin
    if (exp_rx.size() == 0) chk("rx_valid_unexpected", 1, 0);
    else begin
      chk("rx_data", rx_data, exp_rx.pop_front());
      if (got_mo.size() == 0) chk("mosi_edges_done", 0, 1);
      else chk("mosi_word", got_mo.pop_front(), exp_mo[0]);
      void'(exp_mo.pop_front());
    end
  end
  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] s, input logic p, input logic l,
                      input logic h, input bit keep);
    int t = 0;
    @(posedge clk_in); #1;
    while (!tx_ready && t < 3000) begin @(posedge clk_in); #1; t++; end
    if (!tx_ready) begin chk("accept_timeout", 0, 1); return; end
    nx_s = s; nx_ph = p; nx_lf = l; nx_hc = h;
    exp_rx.push_back(s);
    exp_mo.push_back(d);
    tx_data = d; cpha = p; lsb_first = l; hold_cs = h; tx_valid = 1;
    @(posedge clk_in); #1;
    tx_data = DW'($urandom); cpha = 1'($urandom); lsb_first = 1'($urandom); hold_cs = 1'($urandom);
    if (!keep) tx_valid = 0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((busy || !spi_cs_n) && t < 3000) begin @(posedge clk_in); #1; t++; end
    chk("idle_reached", {31'd0, busy | ~spi_cs_n}, 0);
  endtask
  initial begin
    rst_n = 0; tx_valid = 0; tx_data = '0; cpha = 0; lsb_first = 0; hold_cs = 0; spi_miso = 0;
    repeat (3) @(posedge clk_in);
    #3;
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_clk_run", clk_run, 0);
    chk("rst_clk_tog", clk_tog, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk_in); #1;
    rst_n = 1;
    send(8'hA5, 8'hA5, 0, 0, 0, 0);
    wait_idle();
    dens = 40;
    send(8'h96, 8'h3C, 1, 1, 0, 0);
    wait_idle();
    dens = 50;
    send(DW'($urandom), DW'($urandom), 0, 0, 1, 0);
    send(DW'($urandom), DW'($urandom), 1, 0, 0, 0);
    wait_idle();
    dens = 100;
    send(8'h5A, 8'hC3, 0, 0, 0, 0);
    begin
      int t = 0;
      while (!(act && e == 7) && t < 200) begin @(posedge clk_in); #1; t++; end
      chk("reach_ec7", {31'd0, act && e == 7}, 1);
    end
    rst_n = 0;
    #1;
    chk("midrst_cs_n", spi_cs_n, 1);
    chk("midrst_tx_ready", tx_ready, 1);
    chk("midrst_clk_tog", clk_tog, 0);
    chk("midrst_busy", busy, 0);
    exp_rx.delete(); exp_mo.delete(); got_mo.delete();
    act = 0; held = 0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1;
    send(8'h81, 8'h7E, 1, 0, 0, 0);
    wait_idle();
    send(8'hE7, 8'h18, 0, 1, 0, 1);
    begin
      int t = 0;
      while (!rx_valid && t < 300) begin @(posedge clk_in); #1; t++; end
      chk("held_valid_rx", rx_valid, 1);
    end
    tx_valid = 0;
    wait_idle();
    repeat (40) begin
      dens = ($urandom_range(0, 2) == 0) ? 100 : $urandom_range(15, 80);
      send(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    end
    send(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), 0, 0);
    wait_idle();
    repeat (3) @(posedge clk_in);
    #1;
    chk("extra_edges", extra, 0);
    chk("words_pending", exp_rx.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
